twi_master: RTL

//  Single-master I2C initiator on clk_16mhz. It drives the power I2C bus on its own, without the host.

---
 rtl/twi_master.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/twi_master.sv
// Single-master I2C register initiator: START, device address, register address, then either
// one write byte or a repeated START and one read byte, then STOP. Outputs are pull-low enables.
module twi_master #(
  parameter int DIV = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] devAddr,
  input  logic [7:0] regAddr,
  input  logic [7:0] wrData,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sclLow,
  output logic       sdaLow,
  output logic       busy,
  output logic       done,
  output logic       ackErr,
  output logic [7:0] rdData
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDRW, ACK1, REG, ACK2, WR, ACK3,
    RSTART, ADDRR, ACK4, RD, MNACK, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            sample_q, sample_d;
  logic            rw_q, rw_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wr_q, wr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            scl_low_q, scl_low_d;
  logic            sda_low_q, sda_low_d;
  logic            hold, step, bit_end, sample_now;

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;

    // A slave holding SCL low after we release it freezes the Q1 timer.
    hold       = (quarter_q == 2'd1) && !sclIn && (state_q != IDLE) && (state_q != START);
    step       = (state_q != IDLE) && !hold && (cnt_q == CNT_LAST);
    bit_end    = step && (quarter_q == 2'd3);
    sample_now = (state_q != IDLE) && (quarter_q == 2'd2) && (cnt_q == '0);

    if ((state_q != IDLE) && !hold) begin
      if (step) begin
        cnt_d     = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (sample_now) begin
      sample_d = sdaIn;
      if (state_q == RD) shift_d = {shift_q[6:0], sdaIn};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rw_d      = rw;
          dev_d     = devAddr;
          reg_d     = regAddr;
          wr_d      = wrData;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          quarter_d = 2'd0;
          state_d   = START;
        end
      end
      START: begin
        if (step && (quarter_q == 2'd1)) begin
          quarter_d = 2'd0;
          bit_d     = 3'd0;
          shift_d   = {dev_q, 1'b0};
          state_d   = ADDRW;
        end
      end
      ADDRW, REG, WR, ADDRR: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            case (state_q)
              ADDRW:   state_d = ACK1;
              REG:     state_d = ACK2;
              WR:      state_d = ACK3;
              default: state_d = ACK4;
            endcase
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      ACK1, ACK2, ACK3, ACK4: begin
        if (bit_end) begin
          bit_d = 3'd0;
          if (sample_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            case (state_q)
              ACK1: begin
                shift_d = reg_q;
                state_d = REG;
              end
              ACK2: begin
                shift_d = wr_q;
                state_d = rw_q ? RSTART : WR;
              end
              ACK3:    state_d = STOP;
              default: state_d = RD;
            endcase
          end
        end
      end
      RSTART: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          shift_d = {dev_q, 1'b1};
          state_d = ADDRR;
        end
      end
      RD: begin
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = MNACK;
          else bit_d = bit_q + 3'd1;
        end
      end
      MNACK: begin
        if (bit_end) begin
          rd_data_d = shift_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Line levels are derived from the next state so they register together with it.
    case (state_d)
      IDLE: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
      end
      START: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b1;
      end
      ADDRW, REG, WR, ADDRR: begin
        scl_low_d = (quarter_d == 2'd0);
        sda_low_d = !shift_d[7];
      end
      RSTART: begin
        scl_low_d = (quarter_d == 2'd0);
        sda_low_d = quarter_d[1];
      end
      STOP: begin
        scl_low_d = (quarter_d == 2'd0);
        sda_low_d = !quarter_d[1];
      end
      default: begin
        scl_low_d = (quarter_d == 2'd0);
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      quarter_q <= 2'd0;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      sample_q  <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wr_q      <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= 8'd0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign sclLow = scl_low_q;
  assign sdaLow = sda_low_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ackErr = ack_err_q;
  assign rdData = rd_data_q;
endmodule
